// File: rtl/add_pkg.sv
// Shared types and constants for the sequential multi-byte adder.
package add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int BYTE_W = 8;

   // Bits needed to index n bytes, never less than one so NBYTES=1 still
   // gets a real counter.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/prefix_adder.sv
// 8-bit parallel-prefix (Kogge-Stone) adder with carry in/out.
module prefix_adder (
   input  logic [7:0] term0,
   input  logic [7:0] term1,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [7:0] g, p, gg, pp, ng, np;
   logic [8:0] c;

   // Prefix tree over generate/propagate, then fold in cin per bit.
   always_comb begin
      g  = term0 & term1;
      p  = term0 ^ term1;
      gg = g;
      pp = p;
      ng = g;
      np = p;
      for (int d = 1; d < 8; d = d * 2) begin
         ng = gg;
         np = pp;
         for (int i = d; i < 8; i++) begin
            ng[i] = gg[i] | (pp[i] & gg[i-d]);
            np[i] = pp[i] & pp[i-d];
         end
         gg = ng;
         pp = np;
      end
      c    = {gg | (pp & {8{cin}}), cin};
      sum  = p ^ c[7:0];
      cout = c[8];
   end

endmodule

// File: rtl/multibyte_add_seq.sv
// Wide adder that time-multiplexes one 8-bit prefix adder, LSB byte first,
// with valid/ready handshakes on both sides.
module multibyte_add_seq
   import add_pkg::*;
#(
   parameter  int NBYTES = 4,
   localparam int W      = BYTE_W * NBYTES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         busy
);

   localparam int              IDXW = idx_width(NBYTES);
   localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

   state_e            state_q, state_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic              cout_q, cout_d, ovf_q, ovf_d;

   logic [BYTE_W-1:0] a_byte, b_byte, add_sum;
   logic              add_cout;

   assign a_byte = a_q[BYTE_W*idx_q +: BYTE_W];
   assign b_byte = b_q[BYTE_W*idx_q +: BYTE_W];

   prefix_adder u_add (
      .term0 (a_byte),
      .term1 (b_byte),
      .cin   (carry_q),
      .sum   (add_sum),
      .cout  (add_cout)
   );

   // Next-state: capture in IDLE, one byte per cycle in RUN, hold in DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[BYTE_W*idx_q +: BYTE_W] = add_sum;
            carry_d = add_cout;
            if (idx_q == LAST) begin
               // Top byte just landed in sum_d, so overflow sees the final sign.
               idx_d   = '0;
               cout_d  = add_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Bench for multibyte_add_seq: a cycle-level transaction model (accept edge,
// latency, result from plain integer addition) checked every cycle, plus
// directed vectors with literal expectations.
module tb_multibyte_add_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
   logic [W-1:0] a, b, sum;

   int nchk = 0;
   int nfail = 0;
   int cyc = 0;

   multibyte_add_seq #(.NBYTES(NB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- transaction model ----------------
   bit           pend = 0;
   int           acc_cyc = 0;
   logic [W-1:0] m_sum;
   logic         m_cout, m_ovf;
   int           acc_q[$];

   // Sampled at negedge: check outputs for the state implied by the model,
   // then apply the handshakes the coming posedge will see.
   always @(negedge clk) begin
      bit           e_rdy, e_ov;
      logic [W:0]   t;
      if (!rst_n) begin
         pend = 0;
      end else begin
         e_rdy = !pend;
         e_ov  = pend && (cyc >= acc_cyc + NB);
         check("in_ready", in_ready, e_rdy);
         check("out_valid", out_valid, e_ov);
         check("busy", busy, pend && !e_ov);
         if (e_ov) begin
            check("sum", sum, m_sum);
            check("cout", cout, m_cout);
            check("ovf", ovf, m_ovf);
         end
         if (e_ov && out_ready) begin
            pend = 0;
         end else if (e_rdy && in_valid) begin
            t       = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            m_sum   = t[W-1:0];
            m_cout  = t[W];
            m_ovf   = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
            pend    = 1;
            acc_cyc = cyc + 1;
            acc_q.push_back(cyc + 1);
         end
      end
   end

   // ---------------- directed transaction with literal expectations ----------------
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input int hold, input logic [W-1:0] es, input logic ec, input logic eo);
      bit got;
      int lat;
      @(posedge clk); #1;
      a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      check("accept", got, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
      lat = -1;
      for (int i = 0; i < 30 && lat < 0; i++) begin
         @(negedge clk);
         if (out_valid) lat = i;
      end
      check("latency", lat, NB);
      check("lit_sum", sum, es);
      check("lit_cout", cout, ec);
      check("lit_ovf", ovf, eo);
      repeat (hold) begin
         @(negedge clk);
         check("hold_sum", sum, es);
         check("hold_in_ready", in_ready, 0);
         check("hold_out_valid", out_valid, 1);
      end
      @(posedge clk); #1; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #3; rst_n = 1'b1;

      run_op(32'h000000F0, 32'h0000000F, 1'b1, 0, 32'h00000100, 1'b0, 1'b0);
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 32'h00000000, 1'b1, 1'b0);
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 32'h80000000, 1'b0, 1'b1);
      run_op(32'h80000000, 32'h80000000, 1'b0, 0, 32'h00000000, 1'b1, 1'b1);
      run_op(32'hB4B4B4B4, 32'h49494949, 1'b0, 5, 32'hFDFDFDFD, 1'b0, 1'b0);

      // Reset in the middle of RUN
      @(posedge clk); #1; a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #3; rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_sum", sum, 0);
      check("abort_busy", busy, 0);
      @(posedge clk); #3; rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1);
      run_op(32'h00000000, 32'h000000EF, 1'b0, 0, 32'h000000EF, 1'b0, 1'b0);

      // Back-to-back: in_valid held with operands churning every cycle
      acc_q.delete();
      @(posedge clk); #1; out_ready = 1'b1; in_valid = 1'b1;
      repeat (30) begin
         a = $urandom; b = $urandom; cin = 1'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("b2b_accepts", acc_q.size() >= 3, 1);
      for (int i = 1; i < acc_q.size(); i++)
         check("b2b_period", acc_q[i] - acc_q[i-1], NB + 2);
      repeat (NB + 3) @(posedge clk);

      // Randomized traffic with random backpressure
      repeat (400) begin
         #1;
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? ~a : W'($urandom);
         cin = 1'($urandom);
         @(posedge clk);
      end
      #1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (NB + 4) @(posedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Sequential multi-byte adder built around the existing 8-bit `prefix_adder`.
- Accepts wide operands through a valid/ready handshake and feeds them to one `prefix_adder` instance, one byte per cycle, LSB first.
- Registers the ripple carry between bytes and presents the full-width sum, carry-out and signed overflow through an output handshake.
- Upstream consumers (accumulators, address generators) use it to get wide additions without replicating the 8-bit adder.

Parameters:
- NBYTES, default 4: operand width in bytes; legal range 1..16.
- W, default 8*NBYTES: derived operand width in bits; not overridable.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand set `a`/`b`/`cin` is valid.
- in_ready, output, 1: block can accept operands.
- a, input, W: operand A.
- b, input, W: operand B.
- cin, input, 1: carry into byte 0.
- out_valid, output, 1: `sum`/`cout`/`ovf` are valid.
- out_ready, input, 1: consumer accepts the result.
- sum, output, W: A + B + cin, modulo 2^W.
- cout, output, 1: carry out of bit W-1.
- ovf, output, 1: signed two's-complement overflow.
- busy, output, 1: high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, byte index = 0, carry reg = 0, operand regs = 0, sum = 0, cout = 0, ovf = 0, out_valid = 0, in_ready = 1 once reset is released, busy = 0.
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE), combinational from state.
- out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready at edge E, capture a, b, cin. Carry reg = cin, idx = 0, state -> RUN.
  - If in_valid is low, stay in IDLE.
- RUN:
  - Each cycle, `prefix_adder` receives a[8*idx+:8], b[8*idx+:8] and the carry reg.
  - At the edge, write the 8-bit result to sum[8*idx+:8], set carry reg = adder cout, idx = idx + 1.
  - When idx == NBYTES-1 at the edge: cout = adder cout, compute ovf, state -> DONE, idx wraps to 0.
- Latency: out_valid rises exactly NBYTES cycles after the accept edge E.
- DONE:
  - sum, cout and ovf are held stable while out_valid && !out_ready (any-length backpressure).
  - On out_ready, state -> IDLE at that edge.
- ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), evaluated on the final sum.
- No input/output overlap. Minimum accept-to-accept period is NBYTES+2 cycles when out_ready is held high.
- in_valid during RUN or DONE is ignored; operands are not captured.
- Operand inputs may change freely after the accept edge; only the registered copies are used.
- sum bytes not yet written during RUN are undefined to the consumer; consumers must only sample when out_valid is high.
- NBYTES = 1: RUN lasts one cycle, so latency is 1.
- Reset asserted mid-RUN or in DONE: the operation is aborted with no partial output, and all state returns to reset values immediately.
- Wrap-around: the carry out of the top byte goes only to cout; sum is modulo 2^W.

Decomposition:
- Shared package add_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits.
  - BYTE_W = 8.
  - Index width function clog2(NBYTES), with a minimum of 1.
- One sub-module: the existing `prefix_adder` (term0, term1, cin, sum, cout), instantiated once, unmodified.
- Everything else (FSM, index counter, carry reg, byte write) stays in `multibyte_add_seq`.

Test Plan (NBYTES=4):
- a=0x000000F0, b=0x0000000F, cin=1 -> sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0 (full carry ripple across all bytes).
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Backpressure: a=0xB4B4B4B4, b=0x49494949; hold out_ready=0 for 5 cycles -> sum=0xFDFDFDFD stays stable, in_ready=0 throughout. Raise out_ready -> IDLE, in_ready=1 next cycle.
- Reset mid-RUN: accept a=0x12345678, b=0x11111111; drop rst_n after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 after release. A new add of 0x00000000 + 0x000000EF then returns 0x000000EF.
- Back-to-back with out_ready=1 and in_valid held: second accept occurs NBYTES+2 cycles after the first. in_valid pulses during RUN are not captured (operands unchanged, result correct).
